// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, skip conditions
// and the fetch/decode sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_INPUT    = 4'h5;
    localparam logic [3:0] OP_OUTPUT   = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;

    localparam logic [1:0] COND_LT    = 2'b00;
    localparam logic [1:0] COND_EQ    = 2'b01;
    localparam logic [1:0] COND_GT    = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } fd_state_t;

endpackage

// File: rtl/ir_decoder.sv
// Combinational split of an instruction word into its opcode, operand
// address and skip-condition fields.
module ir_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [11:0]       operand,
    output logic [1:0]        cond,
    output logic              is_halt
);

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[11:0];
    // The condition overlaps the top of the operand field for SKIPCOND.
    assign cond    = ir[11:10];
    assign is_halt = (opcode == OP_HALT);

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch/decode sequencer: owns the PC, fetches over req/ack,
// issues decoded fields over valid/ready and applies skip/jump redirects.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_opcode,
    output logic [11:0]       ex_operand,
    output logic [1:0]        ex_cond,
    input  logic              ex_done,
    input  logic              skip_take,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fd_state_t         state;
    fd_state_t         next_state;
    logic [DATA_W-1:0] ir;
    logic [3:0]        dec_opcode;
    logic [11:0]       dec_operand;
    logic [1:0]        dec_cond;
    logic              dec_is_halt;

    ir_decoder #(.DATA_W(DATA_W)) u_ir_decoder (
        .ir      (ir),
        .opcode  (dec_opcode),
        .operand (dec_operand),
        .cond    (dec_cond),
        .is_halt (dec_is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_BOOT:   next_state = ST_FETCH;
            ST_FETCH:  if (mem_ack) next_state = ST_DECODE;
            ST_DECODE: next_state = dec_is_halt ? ST_HALT : ST_ISSUE;
            ST_ISSUE:  if (ex_ready) next_state = ST_EXEC;
            ST_EXEC:   if (ex_done) next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_BOOT;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign mem_req  = (state == ST_FETCH);
    assign ex_valid = (state == ST_ISSUE);
    assign halted   = (state == ST_HALT);
    assign mem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= '0;
            ex_opcode  <= '0;
            ex_operand <= '0;
            ex_cond    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                ST_DECODE: begin
                    ex_opcode  <= dec_opcode;
                    ex_operand <= dec_operand;
                    ex_cond    <= dec_cond;
                end
                ST_EXEC: begin
                    // Jump outranks skip; pc already points past the instruction.
                    if (ex_done) begin
                        if (jump_valid) begin
                            pc <= jump_target;
                        end else if (skip_take) begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
